draw_arbiter: RTL and testbench
===============================

Name: draw_arbiter

Overview:
- N-channel arbiter that lets several full-screen or sprite draw engines share the single VGA adapter pixel-write port.
- Latches per-channel draw requests and grants one engine at a time, round-robin.
- Pulses the granted engine's start input, routes its x/y/colour/plot to the adapter, and holds the grant until that engine signals done.
- Replaces the location-keyed pixel mux and OR-ed write/done in the top level.

Parameters:
- NUM_CH, 4, number of draw channels (2..16).
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- C_W, 8, colour width.
- TIMEOUT_CYCLES, 32768, watchdog limit in clk cycles; used only with DRAW_TIMEOUT_EN.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_CH  per-channel draw request pulse/level; sampled every cycle.
- ch_start  out  NUM_CH  one-cycle start pulse to the granted engine.
- ch_x  in  NUM_CH*X_W  packed x per channel; channel i at [i*X_W +: X_W].
- ch_y  in  NUM_CH*Y_W  packed y per channel.
- ch_colour  in  NUM_CH*C_W  packed colour per channel.
- ch_write  in  NUM_CH  per-channel plot strobe.
- ch_done  in  NUM_CH  per-channel draw-complete pulse.
- x  out  X_W  pixel x to the VGA adapter.
- y  out  Y_W  pixel y to the VGA adapter.
- colour  out  C_W  pixel colour to the VGA adapter.
- plot  out  1  pixel write enable to the VGA adapter.
- busy  out  1  high while a grant is held.
- grant_id  out  4  index of the current or last granted channel.
- pending  out  NUM_CH  latched, not-yet-served requests.
- timeout  out  1  one-cycle pulse when the watchdog aborts a grant.

Behaviour:
- Reset (async, active-high) clears all state:
  - state=IDLE; pending=0; grant_id=0; last-served pointer=NUM_CH-1.
  - ch_start=0; busy=0; plot=0; x/y/colour=0; timeout=0.
- Request latch:
  - pending[i] <= pending[i] | req[i] every cycle.
  - pending[i] is cleared only in the cycle channel i is granted.
  - req[i] asserted in the same cycle as its grant re-sets pending[i], queuing one more draw; requests never count above 1 per channel.
- FSM states: IDLE, LAUNCH, BUSY.
  - IDLE: if pending != 0, select the first set bit scanning upward from (last+1) mod NUM_CH, wrapping. Register grant_id, clear that pending bit, set last=grant_id, go to LAUNCH. If pending == 0, stay in IDLE.
  - LAUNCH (1 cycle): ch_start[grant_id]=1 (registered output, so the pulse is visible exactly this cycle); busy=1; go to BUSY.
  - BUSY: busy=1. On ch_done[grant_id]=1 go to IDLE. busy drops the cycle after done is seen. Earliest next LAUNCH is 2 cycles after done.
- Latency: req at cycle n → pending at n+1 → grant registered in IDLE at n+1 → ch_start at n+2.
- Pixel path (combinational from grant_id and state):
  - In LAUNCH/BUSY: x/y/colour = selected channel slice; plot = ch_write[grant_id].
  - In IDLE: plot=0; x/y/colour hold the last granted slice.
  - ch_write, ch_done and pixel data from non-granted channels are ignored.
- A ch_done from the granted channel during LAUNCH is ignored. Engines must not assert done in the same cycle as start.
- grant_id is zero-extended to 4 bits.
- Reset mid-BUSY: aborts immediately; plot drops asynchronously; no start is reissued after reset releases.

Optional Feature:
- Macro DRAW_TIMEOUT_EN.
- Defined:
  - A cycle counter (width $clog2(TIMEOUT_CYCLES)+1) clears on LAUNCH and increments in BUSY.
  - If it reaches TIMEOUT_CYCLES without ch_done: pulse timeout for 1 cycle, force IDLE, leave that channel's pending bit clear (its draw is dropped).
  - A done arriving in the same cycle as the limit counts as normal completion; timeout is not pulsed.
- Undefined: no counter; timeout tied to 0; BUSY waits indefinitely.

Test Plan:
- Reset, then req=4'b0001 for 1 cycle → ch_start=4'b0001 exactly 2 cycles later. With ch_write=1, ch_x[0]=8'd10 → x=10, plot=1. ch_done[0] → busy=0 the next cycle.
- Simultaneous req=4'b1011 from IDLE after reset (last=3) → grants in order 0, 1, 3; pending shows 4'b1010 then 4'b1000 then 0.
- Round-robin fairness: channels 0 and 2 re-request continuously → grants alternate 0, 2, 0, 2; no channel is granted twice in a row.
- Foreign strobes: ch_write[2]=1 and ch_done[2]=1 while channel 1 is granted → plot follows only ch_write[1]; BUSY persists until ch_done[1].
- Reset asserted mid-BUSY with pending=4'b0100 → busy, plot and pending=0 immediately; no ch_start after reset deasserts.
- With DRAW_TIMEOUT_EN and TIMEOUT_CYCLES=16: grant channel 3 and never assert done → timeout pulses 16 cycles into BUSY, state returns to IDLE, and the next pending channel is launched.

Source files
------------

// File: rtl/draw_arbiter.sv
// draw_arbiter: round-robin arbiter that shares the VGA pixel-write port among NUM_CH draw engines.
// Define DRAW_TIMEOUT_EN to add a watchdog that aborts a grant held longer than TIMEOUT_CYCLES.
module draw_arbiter #(
   parameter int unsigned NUM_CH         = 4,
   parameter int unsigned X_W            = 8,
   parameter int unsigned Y_W            = 7,
   parameter int unsigned C_W            = 8,
   parameter int unsigned TIMEOUT_CYCLES = 32768
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_CH-1:0]     req,
   output logic [NUM_CH-1:0]     ch_start,
   input  logic [NUM_CH*X_W-1:0] ch_x,
   input  logic [NUM_CH*Y_W-1:0] ch_y,
   input  logic [NUM_CH*C_W-1:0] ch_colour,
   input  logic [NUM_CH-1:0]     ch_write,
   input  logic [NUM_CH-1:0]     ch_done,
   output logic [X_W-1:0]        x,
   output logic [Y_W-1:0]        y,
   output logic [C_W-1:0]        colour,
   output logic                  plot,
   output logic                  busy,
   output logic [3:0]            grant_id,
   output logic [NUM_CH-1:0]     pending,
   output logic                  timeout
);

   localparam int unsigned ID_W  = 4;
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

   typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [ID_W-1:0]    last_q;
   logic               grant_now;

   logic               hi_vld;
   logic [ID_W-1:0]    hi_id;
   logic [ID_W-1:0]    lo_id;
   logic [NUM_CH-1:0]  hi_mask;
   logic [NUM_CH-1:0]  lo_mask;
   logic [ID_W-1:0]    sel_id;
   logic [NUM_CH-1:0]  sel_mask;

   logic [NUM_CH-1:0]  pending_nxt;
   logic [NUM_CH-1:0]  start_nxt;
   logic               busy_nxt;

   logic [X_W-1:0]     x_sel;
   logic [Y_W-1:0]     y_sel;
   logic [C_W-1:0]     colour_sel;
   logic               write_sel;
   logic               done_sel;

   logic [X_W-1:0]     x_hold;
   logic [Y_W-1:0]     y_hold;
   logic [C_W-1:0]     colour_hold;

   logic               expire;

   assign grant_now = (state == IDLE) && (pending != '0);

   // Round-robin pick: lowest pending index above last, else lowest pending index overall.
   always_comb begin : rr_select
      hi_vld  = 1'b0;
      hi_id   = '0;
      lo_id   = '0;
      hi_mask = '0;
      lo_mask = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (pending[i]) begin
            lo_id      = ID_W'(i);
            lo_mask    = '0;
            lo_mask[i] = 1'b1;
            if (ID_W'(i) > last_q) begin
               hi_vld     = 1'b1;
               hi_id      = ID_W'(i);
               hi_mask    = '0;
               hi_mask[i] = 1'b1;
            end
         end
      end
      sel_id   = hi_vld ? hi_id   : lo_id;
      sel_mask = hi_vld ? hi_mask : lo_mask;
   end

   // Granted-channel slice and strobes; everything from other channels is ignored.
   always_comb begin : grant_mux
      x_sel      = '0;
      y_sel      = '0;
      colour_sel = '0;
      write_sel  = 1'b0;
      done_sel   = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ID_W'(i) == grant_id) begin
            x_sel      = ch_x[i*X_W +: X_W];
            y_sel      = ch_y[i*Y_W +: Y_W];
            colour_sel = ch_colour[i*C_W +: C_W];
            write_sel  = ch_write[i];
            done_sel   = ch_done[i];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; done during LAUNCH is deliberately not looked at.
   always_comb begin : next_state
      state_nxt = state;
      case (state)
         IDLE:    if (pending != '0) state_nxt = LAUNCH;
         LAUNCH:  state_nxt = BUSY;
         BUSY:    if (done_sel || expire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: next values for registered outputs plus the combinational pixel path.
   always_comb begin : outputs
      start_nxt   = '0;
      busy_nxt    = (state_nxt != IDLE);
      pending_nxt = pending | req;
      if (grant_now) begin
         start_nxt   = sel_mask;
         pending_nxt = (pending & ~sel_mask) | req;
      end
      if (state == IDLE) begin
         x      = x_hold;
         y      = y_hold;
         colour = colour_hold;
         plot   = 1'b0;
      end else begin
         x      = x_sel;
         y      = y_sel;
         colour = colour_sel;
         plot   = write_sel;
      end
   end

   // Grant bookkeeping, request latch, registered outputs and the idle pixel hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending     <= '0;
         grant_id    <= '0;
         last_q      <= ID_W'(NUM_CH - 1);
         ch_start    <= '0;
         busy        <= 1'b0;
         x_hold      <= '0;
         y_hold      <= '0;
         colour_hold <= '0;
      end else begin
         pending  <= pending_nxt;
         ch_start <= start_nxt;
         busy     <= busy_nxt;
         if (grant_now) begin
            grant_id <= sel_id;
            last_q   <= sel_id;
         end
         if (state != IDLE) begin
            x_hold      <= x_sel;
            y_hold      <= y_sel;
            colour_hold <= colour_sel;
         end
      end
   end

`ifdef DRAW_TIMEOUT_EN
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             timeout_q;

   assign cnt_inc = cnt + CNT_W'(1);
   // A done in the limit cycle wins over the watchdog.
   assign expire  = (state == BUSY) && !done_sel && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
   assign timeout = timeout_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= expire;
         if (state == LAUNCH) begin
            cnt <= '0;
         end else if (state == BUSY) begin
            cnt <= cnt_inc;
         end
      end
   end
`else
   logic [CNT_W-1:0] unused_timeout_cfg;

   assign unused_timeout_cfg = CNT_W'(TIMEOUT_CYCLES);
   assign expire             = 1'b0;
   assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_draw_arbiter.sv
// tb_draw_arbiter: directed bench; launches are checked by a monitor against an expected-launch queue.
// Building with DRAW_TIMEOUT_EN adds the watchdog scenario.
`timescale 1ns/1ps
module tb_draw_arbiter;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned X_W    = 8;
   localparam int unsigned Y_W    = 7;
   localparam int unsigned C_W    = 8;
   localparam int unsigned TO_CYC = 16;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NUM_CH-1:0]     req;
   logic [NUM_CH-1:0]     ch_start;
   logic [NUM_CH*X_W-1:0] ch_x;
   logic [NUM_CH*Y_W-1:0] ch_y;
   logic [NUM_CH*C_W-1:0] ch_colour;
   logic [NUM_CH-1:0]     ch_write;
   logic [NUM_CH-1:0]     ch_done;
   logic [X_W-1:0]        x;
   logic [Y_W-1:0]        y;
   logic [C_W-1:0]        colour;
   logic                  plot;
   logic                  busy;
   logic [3:0]            grant_id;
   logic [NUM_CH-1:0]     pending;
   logic                  timeout;

   typedef struct {
      logic [NUM_CH-1:0] start;
      logic [NUM_CH-1:0] pend;
      int                cyc;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   g;

   draw_arbiter #(
      .NUM_CH(NUM_CH), .X_W(X_W), .Y_W(Y_W), .C_W(C_W), .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .ch_start(ch_start),
      .ch_x(ch_x), .ch_y(ch_y), .ch_colour(ch_colour),
      .ch_write(ch_write), .ch_done(ch_done),
      .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy),
      .grant_id(grant_id), .pending(pending), .timeout(timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int enc(input logic [NUM_CH-1:0] v);
      enc = -1;
      for (int i = 0; i < NUM_CH; i++) if (v[i]) enc = i;
   endfunction

   task automatic expect_launch(input logic [NUM_CH-1:0] s, input logic [NUM_CH-1:0] p, input int c);
      exp_t e;
      e.start = s;
      e.pend  = p;
      e.cyc   = c;
      sbq.push_back(e);
   endtask

   // Monitor: every start pulse must match the head of the expected-launch queue.
   always @(negedge clk) begin
      if (ch_start != '0) begin
         if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_start: ch_start=%b with no launch expected (cycle %0d)", ch_start, cyc);
         end else begin
            mon_e = sbq.pop_front();
            check("launch_start", 32'(ch_start), 32'(mon_e.start));
            check("launch_grant_id", 32'(grant_id), 32'(enc(mon_e.start)));
            check("launch_pending", 32'(pending), 32'(mon_e.pend));
            if (mon_e.cyc >= 0) check("launch_cycle", 32'(cyc), 32'(mon_e.cyc));
         end
      end
   end

   task automatic do_reset();
      reset    = 1'b1;
      req      = '0;
      ch_write = '0;
      ch_done  = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_start(output int gid);
      gid = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (ch_start != '0) begin
            gid = enc(ch_start);
            break;
         end
      end
      if (gid < 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL launch_wait: no ch_start within 20 cycles (cycle %0d)", cyc);
      end
   endtask

   task automatic finish_draw(input int gid, input int dly);
      repeat (dly) @(negedge clk);
      if (gid >= 0) ch_done = NUM_CH'(1) << gid;
      @(negedge clk);
      ch_done = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "bench time limit");
   end

   initial begin
      reset     = 1'b1;
      req       = '0;
      ch_x      = '0;
      ch_y      = '0;
      ch_colour = '0;
      ch_write  = 4'b0001;
      ch_done   = '0;
      ch_x[7:0]      = 8'd10;
      ch_y[6:0]      = 7'd5;
      ch_colour[7:0] = 8'h3c;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_plot", 32'(plot), 0);
      check("rst_start", 32'(ch_start), 0);
      check("rst_pending", 32'(pending), 0);
      check("rst_grant_id", 32'(grant_id), 0);
      check("rst_x", 32'(x), 0);
      check("rst_timeout", 32'(timeout), 0);
      reset = 1'b0;
      @(negedge clk);

      // Single request: start two cycles later, pixel routed, busy drops after done.
      req = 4'b0001;
      expect_launch(4'b0001, 4'b0000, cyc + 2);
      @(negedge clk);
      req = '0;
      check("t1_no_early_start", 32'(ch_start), 0);
      check("t1_pending_latched", 32'(pending), 32'(4'b0001));
      @(negedge clk);
      check("t1_x", 32'(x), 10);
      check("t1_y", 32'(y), 5);
      check("t1_colour", 32'(colour), 32'h3c);
      check("t1_plot", 32'(plot), 1);
      check("t1_busy_launch", 32'(busy), 1);
      @(negedge clk);
      check("t1_busy_hold", 32'(busy), 1);
      ch_done = 4'b0001;
      @(negedge clk);
      check("t1_busy_after_done", 32'(busy), 0);
      check("t1_plot_idle", 32'(plot), 0);
      ch_done   = '0;
      ch_write  = '0;
      ch_x[7:0] = 8'd200;
      @(negedge clk);
      check("t1_x_held_idle", 32'(x), 10);

      // Simultaneous requests after reset: order 0, 1, 3.
      do_reset();
      req = 4'b1011;
      expect_launch(4'b0001, 4'b1010, -1);
      expect_launch(4'b0010, 4'b1000, -1);
      expect_launch(4'b1000, 4'b0000, -1);
      @(negedge clk);
      req = '0;
      for (int k = 0; k < 3; k++) begin
         wait_start(g);
         finish_draw(g, 1);
      end

      // Continuous requests from 0 and 2 alternate.
      do_reset();
      req = 4'b0101;
      expect_launch(4'b0001, 4'b0101, -1);
      expect_launch(4'b0100, 4'b0101, -1);
      expect_launch(4'b0001, 4'b0101, -1);
      expect_launch(4'b0100, 4'b0101, -1);
      expect_launch(4'b0001, 4'b0100, -1);
      expect_launch(4'b0100, 4'b0000, -1);
      for (int k = 0; k < 3; k++) begin
         wait_start(g);
         finish_draw(g, 1);
      end
      wait_start(g);
      req = '0;
      finish_draw(g, 1);
      for (int k = 0; k < 2; k++) begin
         wait_start(g);
         finish_draw(g, 2);
      end

      // Foreign write/done from channel 2 while channel 1 holds the grant.
      do_reset();
      ch_x[15:8]  = 8'd77;
      ch_x[23:16] = 8'd99;
      ch_write    = 4'b0100;
      ch_done     = 4'b0100;
      req         = 4'b0010;
      expect_launch(4'b0010, 4'b0000, -1);
      @(negedge clk);
      req = '0;
      wait_start(g);
      check("t4_x_granted", 32'(x), 77);
      check("t4_plot_foreign", 32'(plot), 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t4_busy_foreign_done", 32'(busy), 1);
         check("t4_plot_foreign_hold", 32'(plot), 0);
      end
      ch_write = 4'b0110;
      @(negedge clk);
      check("t4_plot_own", 32'(plot), 1);
      ch_done = 4'b0110;
      @(negedge clk);
      check("t4_busy_own_done", 32'(busy), 0);
      ch_done  = '0;
      ch_write = '0;
      @(negedge clk);

      // Reset mid-BUSY with channel 2 pending: everything clears, nothing relaunches.
      req = 4'b0001;
      expect_launch(4'b0001, 4'b0000, -1);
      @(negedge clk);
      req = '0;
      wait_start(g);
      ch_write = 4'b0001;
      req      = 4'b0100;
      @(negedge clk);
      req = '0;
      @(negedge clk);
      check("t5_pending_before", 32'(pending), 32'(4'b0100));
      check("t5_plot_before", 32'(plot), 1);
      #2 reset = 1'b1;
      #1;
      check("t5_busy_async", 32'(busy), 0);
      check("t5_plot_async", 32'(plot), 0);
      check("t5_pending_async", 32'(pending), 0);
      @(negedge clk);
      reset    = 1'b0;
      ch_write = '0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("t5_no_restart", 32'(ch_start), 0);
      end

`ifdef DRAW_TIMEOUT_EN
      // Watchdog: channel 3 never finishes; channel 0 launches after the abort.
      begin
         int tk;
         tk = -1;
         do_reset();
         req = 4'b1000;
         expect_launch(4'b1000, 4'b0000, -1);
         @(negedge clk);
         req = '0;
         wait_start(g);
         req = 4'b0001;
         expect_launch(4'b0001, 4'b0000, -1);
         for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) req = '0;
            if (timeout) begin
               tk = k;
               break;
            end
         end
         check("t6_timeout_cycle", 32'(tk), 17);
         check("t6_busy_at_timeout", 32'(busy), 0);
         wait_start(g);
         finish_draw(g, 1);
      end
`endif

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(sbq.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
